// File: rtl/fir_lane_sequencer_pkg.sv
// Shared types, default configuration and lane-mask helper for the FIR lane sequencer.
package fir_seq_pkg;

    localparam int H_ADDR_WIDTH_DEF = 4;
    localparam int X_ADDR_WIDTH_DEF = 6;
    localparam int NUM_LANES_DEF    = 4;
    localparam int RD_LATENCY_DEF   = 1;
    localparam int MAC_LATENCY_DEF  = 4;

    localparam int X_DEPTH      = 2 ** X_ADDR_WIDTH_DEF;
    localparam int H_DEPTH      = 2 ** H_ADDR_WIDTH_DEF;
    localparam int DRAIN_CYCLES = RD_LATENCY_DEF + MAC_LATENCY_DEF;
    localparam int MAX_LANES    = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        CAPTURE
    } seq_state_e;

    // Lane j of batch b is active while its output index b*lanes+j is below n.
    function automatic logic [MAX_LANES-1:0] lane_mask_f(input int unsigned b,
                                                         input int unsigned n,
                                                         input int unsigned lanes);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned j = 0; j < MAX_LANES; j++) begin
            m[j] = (j < lanes) && ((b * lanes + j) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/fir_lane_sequencer_if.sv
// Job handshake and memory/MAC control bus between the sequencer and the FIR datapath.
interface fir_lane_sequencer_if
    import fir_seq_pkg::*;
#(
    parameter int H_ADDR_WIDTH = H_ADDR_WIDTH_DEF,
    parameter int X_ADDR_WIDTH = X_ADDR_WIDTH_DEF,
    parameter int NUM_LANES    = NUM_LANES_DEF
) ();

    logic                              start_i;
    logic [H_ADDR_WIDTH:0]             num_taps_i;
    logic [X_ADDR_WIDTH:0]             num_out_i;
    logic                              busy_o;
    logic                              done_o;
    logic                              cfg_err_o;
    logic                              rd_en_o;
    logic [H_ADDR_WIDTH-1:0]           h_addr_o;
    logic [NUM_LANES*X_ADDR_WIDTH-1:0] x_addr_o;
    logic [NUM_LANES-1:0]              lane_mask_o;
    logic                              mac_en_o;
    logic                              mac_first_o;
    logic                              y_valid_o;
    logic [NUM_LANES-1:0]              y_lane_mask_o;
    logic [X_ADDR_WIDTH-1:0]           batch_idx_o;

    modport master (
        input  start_i, num_taps_i, num_out_i,
        output busy_o, done_o, cfg_err_o, rd_en_o, h_addr_o, x_addr_o, lane_mask_o,
               mac_en_o, mac_first_o, y_valid_o, y_lane_mask_o, batch_idx_o
    );

    modport slave (
        output start_i, num_taps_i, num_out_i,
        input  busy_o, done_o, cfg_err_o, rd_en_o, h_addr_o, x_addr_o, lane_mask_o,
               mac_en_o, mac_first_o, y_valid_o, y_lane_mask_o, batch_idx_o
    );

endinterface

// File: rtl/fir_lane_sequencer_align_dly.sv
// Fixed-depth shift register aligning read-side controls to the MAC input stage.
module fir_seq_align_dly #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = d_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fir_lane_sequencer.sv
// Batch sequencer for the parallel FIR lanes: tap fetch, MAC drain and per-batch capture.
module fir_lane_sequencer
    import fir_seq_pkg::*;
#(
    parameter int H_ADDR_WIDTH = H_ADDR_WIDTH_DEF,
    parameter int X_ADDR_WIDTH = X_ADDR_WIDTH_DEF,
    parameter int NUM_LANES    = NUM_LANES_DEF,
    parameter int RD_LATENCY   = RD_LATENCY_DEF,
    parameter int MAC_LATENCY  = MAC_LATENCY_DEF
) (
    input logic           clk,
    input logic           rst_n,
    fir_lane_sequencer_if.master bus
);

    localparam int HW      = H_ADDR_WIDTH;
    localparam int XW      = X_ADDR_WIDTH;
    localparam int NL      = NUM_LANES;
    localparam int XDEPTH  = 2 ** XW;
    localparam int HDEPTH  = 2 ** HW;
    localparam int DRAIN_N = RD_LATENCY + MAC_LATENCY;
    localparam int CW      = $clog2(DRAIN_N + 1);

    seq_state_e         state_q, state_d;
    logic [HW-1:0]      k_q, k_d;
    logic [XW-1:0]      b_q, b_d;
    logic [HW:0]        t_q, t_d;
    logic [XW:0]        n_q, n_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;
    logic               rd_en_q, rd_en_d;
    logic               first_q, first_d;
    logic [HW-1:0]      h_addr_q, h_addr_d;
    logic [NL*XW-1:0]   x_addr_q, x_addr_d;
    logic [NL-1:0]      lane_mask_q, lane_mask_d;
    logic               y_valid_q, y_valid_d;
    logic [NL-1:0]      y_mask_q, y_mask_d;
    logic [XW-1:0]      batch_q, batch_d;

    logic               cfg_ok;
    logic [NL-1:0]      mask_next;
    logic [1:0]         mac_dly;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        b_d       = b_q;
        t_d       = t_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;

        cfg_ok = (|bus.num_taps_i) && (int'(bus.num_taps_i) <= HDEPTH) &&
                 (|bus.num_out_i) &&
                 ((int'(bus.num_out_i) + int'(bus.num_taps_i) - 1) <= XDEPTH);

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    if (cfg_ok) begin
                        state_d = FETCH;
                        t_d     = bus.num_taps_i;
                        n_d     = bus.num_out_i;
                        b_d     = '0;
                        k_d     = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if ({1'b0, k_q} == (t_q - 1'b1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(DRAIN_N - 1)) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                if (((int'(b_q) + 1) * NL) < int'(n_q)) begin
                    state_d = FETCH;
                    b_d     = b_q + 1'b1;
                    k_d     = '0;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the next-state view so they register in step with state_q.
        mask_next   = NL'(lane_mask_f(int'(b_d), int'(n_d), NL));
        busy_d      = (state_d != IDLE);
        rd_en_d     = (state_d == FETCH);
        first_d     = rd_en_d && (k_d == '0);
        h_addr_d    = rd_en_d ? k_d : '0;
        lane_mask_d = rd_en_d ? mask_next : '0;
        x_addr_d    = '0;
        for (int unsigned j = 0; j < NL; j++) begin
            if (rd_en_d && mask_next[j]) begin
                x_addr_d[j*XW +: XW] =
                    XW'(int'(b_d) * NL + int'(j) + int'(t_d) - 1 - int'(k_d));
            end
        end
        y_valid_d = (state_d == CAPTURE);
        y_mask_d  = y_valid_d ? mask_next : '0;
        batch_d   = y_valid_d ? b_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            b_q         <= '0;
            t_q         <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            first_q     <= 1'b0;
            h_addr_q    <= '0;
            x_addr_q    <= '0;
            lane_mask_q <= '0;
            y_valid_q   <= 1'b0;
            y_mask_q    <= '0;
            batch_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            b_q         <= b_d;
            t_q         <= t_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            rd_en_q     <= rd_en_d;
            first_q     <= first_d;
            h_addr_q    <= h_addr_d;
            x_addr_q    <= x_addr_d;
            lane_mask_q <= lane_mask_d;
            y_valid_q   <= y_valid_d;
            y_mask_q    <= y_mask_d;
            batch_q     <= batch_d;
        end
    end

    fir_seq_align_dly #(
        .WIDTH (2),
        .DEPTH (RD_LATENCY)
    ) u_align_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({first_q, rd_en_q}),
        .q_o   (mac_dly)
    );

    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.cfg_err_o     = cfg_err_q;
    assign bus.rd_en_o       = rd_en_q;
    assign bus.h_addr_o      = h_addr_q;
    assign bus.x_addr_o      = x_addr_q;
    assign bus.lane_mask_o   = lane_mask_q;
    assign bus.mac_en_o      = mac_dly[0];
    assign bus.mac_first_o   = mac_dly[1];
    assign bus.y_valid_o     = y_valid_q;
    assign bus.y_lane_mask_o = y_mask_q;
    assign bus.batch_idx_o   = batch_q;

endmodule

// File: tb/tb_fir_lane_sequencer.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor pops and compares them.
module tb_fir_lane_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   ec = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ec <= ec + 1;

    fir_lane_sequencer_if #(.H_ADDR_WIDTH(4), .X_ADDR_WIDTH(6), .NUM_LANES(4)) bus1 ();
    fir_lane_sequencer_if #(.H_ADDR_WIDTH(4), .X_ADDR_WIDTH(6), .NUM_LANES(4)) bus2 ();

    fir_lane_sequencer #(
        .H_ADDR_WIDTH(4), .X_ADDR_WIDTH(6), .NUM_LANES(4), .RD_LATENCY(1), .MAC_LATENCY(4)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    fir_lane_sequencer #(
        .H_ADDR_WIDTH(4), .X_ADDR_WIDTH(6), .NUM_LANES(4), .RD_LATENCY(3), .MAC_LATENCY(6)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        int ec;
        int a;
        int b;
        int c;
    } ev_t;

    ev_t q_rd[$], q_mf[$], q_yv[$], q_dn[$], q_ce[$];
    ev_t q2_me[$], q2_yv[$], q2_dn[$];

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at ec=%0d: got %0d expected %0d", nm, ec, act, exp);
        end
    endfunction

    function automatic void spurious(string nm);
        total++;
        bad++;
        $display("FAIL %s unexpected at ec=%0d: got 1 expected 0", nm, ec);
    endfunction

    function automatic ev_t mk(int e, int a, int b, int c);
        ev_t v;
        v.ec = e; v.a = a; v.b = b; v.c = c;
        return v;
    endfunction

    // Expected events for a default-config job whose acceptance edge left ec at a0.
    // Spec cycle c maps to ec a0+c-1; each batch spans T+RD+MAC+1 = T+6 cycles.
    function automatic void push_job1(int a0, int t, int n, int max_beats);
        int nb, per, base, beats, mask, x, addr;
        nb = (n + 3) / 4;
        per = t + 6;
        beats = 0;
        for (int i = 0; i < nb; i++) begin
            base = a0 + i * per;
            for (int k = 0; k < t; k++) begin
                if (max_beats < 0 || beats < max_beats) begin
                    mask = 0;
                    x = 0;
                    for (int j = 0; j < 4; j++) begin
                        if (i * 4 + j < n) begin
                            mask = mask | (1 << j);
                            addr = i * 4 + j + t - 1 - k;
                            x = x | ((addr & 63) << (j * 6));
                        end
                    end
                    q_rd.push_back(mk(base + k, k, x, mask));
                    if (k == 0) q_mf.push_back(mk(base + 1, 0, 0, 0));
                    beats++;
                end
            end
            if (max_beats < 0) begin
                mask = 0;
                for (int j = 0; j < 4; j++) if (i * 4 + j < n) mask = mask | (1 << j);
                q_yv.push_back(mk(base + t + 5, mask, i, 0));
            end
        end
        if (max_beats < 0) q_dn.push_back(mk(a0 + nb * per, 0, 0, 0));
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (bus1.rd_en_o) begin
            if (q_rd.size() == 0) spurious("rd_en");
            else begin
                e = q_rd.pop_front();
                chk("rd_cycle", ec, e.ec);
                chk("h_addr", int'(bus1.h_addr_o), e.a);
                chk("x_addr", int'(bus1.x_addr_o), e.b);
                chk("lane_mask", int'(bus1.lane_mask_o), e.c);
            end
        end
        if (bus1.mac_first_o) begin
            if (q_mf.size() == 0) spurious("mac_first");
            else begin
                e = q_mf.pop_front();
                chk("mac_first_cycle", ec, e.ec);
                chk("mac_first_en", int'(bus1.mac_en_o), 1);
            end
        end
        if (bus1.y_valid_o) begin
            if (q_yv.size() == 0) spurious("y_valid");
            else begin
                e = q_yv.pop_front();
                chk("y_valid_cycle", ec, e.ec);
                chk("y_lane_mask", int'(bus1.y_lane_mask_o), e.a);
                chk("batch_idx", int'(bus1.batch_idx_o), e.b);
                chk("busy_in_capture", int'(bus1.busy_o), 1);
            end
        end
        if (bus1.done_o) begin
            if (q_dn.size() == 0) spurious("done");
            else begin
                e = q_dn.pop_front();
                chk("done_cycle", ec, e.ec);
                chk("busy_at_done", int'(bus1.busy_o), 0);
            end
        end
        if (bus1.cfg_err_o) begin
            if (q_ce.size() == 0) spurious("cfg_err");
            else begin
                e = q_ce.pop_front();
                chk("cfg_err_cycle", ec, e.ec);
            end
        end
        if (bus2.mac_en_o) begin
            if (q2_me.size() == 0) spurious("mac_en2");
            else begin
                e = q2_me.pop_front();
                chk("mac_en2_cycle", ec, e.ec);
            end
        end
        if (bus2.y_valid_o) begin
            if (q2_yv.size() == 0) spurious("y_valid2");
            else begin
                e = q2_yv.pop_front();
                chk("y_valid2_cycle", ec, e.ec);
                chk("y_lane_mask2", int'(bus2.y_lane_mask_o), e.a);
            end
        end
        if (bus2.done_o) begin
            if (q2_dn.size() == 0) spurious("done2");
            else begin
                e = q2_dn.pop_front();
                chk("done2_cycle", ec, e.ec);
            end
        end
    end

    task automatic start1(input int t, input int n, output int a0);
        @(negedge clk);
        bus1.start_i    = 1'b1;
        bus1.num_taps_i = 5'(t);
        bus1.num_out_i  = 7'(n);
        @(posedge clk);
        #1;
        a0 = ec;
    endtask

    task automatic wait_until(input int tgt);
        while (ec < tgt) @(negedge clk);
    endtask

    task automatic check_quiet1(input string nm);
        chk({nm, "_busy"}, int'(bus1.busy_o), 0);
        chk({nm, "_rd_en"}, int'(bus1.rd_en_o), 0);
        chk({nm, "_mac_en"}, int'(bus1.mac_en_o), 0);
        chk({nm, "_mac_first"}, int'(bus1.mac_first_o), 0);
        chk({nm, "_h_addr"}, int'(bus1.h_addr_o), 0);
        chk({nm, "_x_addr"}, int'(bus1.x_addr_o), 0);
        chk({nm, "_lane_mask"}, int'(bus1.lane_mask_o), 0);
        chk({nm, "_y_valid"}, int'(bus1.y_valid_o), 0);
        chk({nm, "_done"}, int'(bus1.done_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at ec=%0d", ec);
        $fatal(1);
    end

    initial begin
        int a0, a2;
        int err_t[4] = '{0, 17, 16, 16};
        int err_n[4] = '{4, 4, 0, 60};

        rst_n = 1'b1;
        bus1.start_i = 1'b0; bus1.num_taps_i = '0; bus1.num_out_i = '0;
        bus2.start_i = 1'b0; bus2.num_taps_i = '0; bus2.num_out_i = '0;
        repeat (3) @(negedge clk);
        check_quiet1("reset");
        chk("reset_cfg_err", int'(bus1.cfg_err_o), 0);
        chk("reset_batch_idx", int'(bus1.batch_idx_o), 0);
        chk("reset_mac_en2", int'(bus2.mac_en_o), 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Default job: T=16, N=4.
        start1(16, 4, a0);
        push_job1(a0, 16, 4, -1);
        @(negedge clk); bus1.start_i = 1'b0;
        wait_until(a0 + 26);

        // Three batches: T=5, N=10.
        start1(5, 10, a0);
        push_job1(a0, 5, 10, -1);
        @(negedge clk); bus1.start_i = 1'b0;
        wait_until(a0 + 37);

        // Largest accepted window: N+T-1 == 64.
        start1(16, 49, a0);
        push_job1(a0, 16, 49, -1);
        @(negedge clk); bus1.start_i = 1'b0;
        wait_until(a0 + 13 * 22 + 4);

        // Rejected configurations.
        for (int i = 0; i < 4; i++) begin
            start1(err_t[i], err_n[i], a0);
            q_ce.push_back(mk(a0, 0, 0, 0));
            @(negedge clk);
            bus1.start_i = 1'b0;
            chk("cfg_err_busy", int'(bus1.busy_o), 0);
            chk("cfg_err_rd_en", int'(bus1.rd_en_o), 0);
            repeat (3) @(negedge clk);
        end

        // Reset during cycle 8 of FETCH aborts the job.
        start1(16, 4, a0);
        push_job1(a0, 16, 4, 8);
        @(negedge clk); bus1.start_i = 1'b0;
        wait_until(a0 + 7);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet1("abort");
        rst_n = 1'b0;
        repeat (30) @(negedge clk);

        // start held high: ignored while busy, accepted again in the done cycle.
        start1(3, 4, a0);
        push_job1(a0, 3, 4, -1);
        a2 = a0 + 10;
        push_job1(a2, 3, 4, -1);
        wait_until(a2);
        bus1.start_i = 1'b0;
        wait_until(a2 + 14);

        // Longer pipeline: RD_LATENCY=3, MAC_LATENCY=6, T=8, N=4.
        @(negedge clk);
        bus2.start_i    = 1'b1;
        bus2.num_taps_i = 5'd8;
        bus2.num_out_i  = 7'd4;
        @(posedge clk);
        #1;
        a0 = ec;
        for (int k = 0; k < 8; k++) q2_me.push_back(mk(a0 + 3 + k, 0, 0, 0));
        q2_yv.push_back(mk(a0 + 17, 15, 0, 0));
        q2_dn.push_back(mk(a0 + 18, 0, 0, 0));
        @(negedge clk); bus2.start_i = 1'b0;
        wait_until(a0 + 25);

        chk("left_rd", q_rd.size(), 0);
        chk("left_mac_first", q_mf.size(), 0);
        chk("left_y_valid", q_yv.size(), 0);
        chk("left_done", q_dn.size(), 0);
        chk("left_cfg_err", q_ce.size(), 0);
        chk("left_mac_en2", q2_me.size(), 0);
        chk("left_y_valid2", q2_yv.size(), 0);
        chk("left_done2", q2_dn.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_lane_sequencer.md
Name: fir_lane_sequencer

Overview:
Runtime-configurable sequencer for the parallel FIR datapath. It drives the coefficient address, per-lane sample addresses and read enables for NUM_LANES parallel DSP58 MAC lanes, and sends latency-aligned MAC controls. Long output blocks are processed as successive batches of NUM_LANES outputs, with a start/busy/done handshake. It replaces the fixed-length, free-running control unit that sits between the coefficient/sample memories and the DSP lane array.

Parameters:
H_ADDR_WIDTH, 4, coefficient address width; maximum taps is 2^H_ADDR_WIDTH.
X_ADDR_WIDTH, 6, sample address width; X_DEPTH = 2^X_ADDR_WIDTH.
NUM_LANES, 4, number of parallel MAC lanes (>=1).
RD_LATENCY, 1, memory read latency in cycles (>=1).
MAC_LATENCY, 4, DSP58 latency from last MAC input to valid accumulator output (>=1).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-high reset (asserted = 1)
start_i  in  1  start request; sampled only in IDLE
num_taps_i  in  H_ADDR_WIDTH+1  tap count T, captured at start
num_out_i  in  X_ADDR_WIDTH+1  output count N, captured at start
busy_o  out  1  high from accepted start through final capture
done_o  out  1  one-cycle pulse when the job completes
cfg_err_o  out  1  one-cycle pulse when start is rejected
rd_en_o  out  1  memory read enable
h_addr_o  out  H_ADDR_WIDTH  coefficient address
x_addr_o  out  NUM_LANES*X_ADDR_WIDTH  per-lane sample addresses; lane j in bits [j*XW +: XW]
lane_mask_o  out  NUM_LANES  active lanes in the current batch
mac_en_o  out  1  MAC enable, delayed RD_LATENCY from rd_en_o
mac_first_o  out  1  marks tap 0 (accumulator clear), aligned with mac_en_o
y_valid_o  out  1  one-cycle capture strobe for lane outputs
y_lane_mask_o  out  NUM_LANES  lane mask aligned with y_valid_o
batch_idx_o  out  X_ADDR_WIDTH  index of the batch being captured

Behaviour:
- Reset (rst_n=1): state is IDLE and all outputs are 0, including the delay-line contents. Reset mid-job aborts the job immediately; no done_o is produced.
- States: IDLE, FETCH, DRAIN, CAPTURE.
- Start checks in IDLE:
  - start_i=1 with T=0, T>2^H_ADDR_WIDTH, N=0, or N+T-1>X_DEPTH: pulse cfg_err_o next cycle and stay in IDLE.
  - Otherwise latch T and N, set b=0, assert busy_o next cycle and enter FETCH.
- start_i is ignored while busy.
- FETCH runs T cycles, with step k=0..T-1:
  - rd_en_o=1 and h_addr_o=k.
  - Lane j address = b*NUM_LANES + j + T-1-k.
  - Masked lanes drive address 0.
  - lane_mask_o bit j = (b*NUM_LANES+j < N).
- mac_en_o and mac_first_o are rd_en_o and (k==0) delayed RD_LATENCY cycles through a shift register.
- DRAIN: counts RD_LATENCY+MAC_LATENCY cycles after the last FETCH cycle.
- CAPTURE: lasts 1 cycle.
  - y_valid_o=1, y_lane_mask_o=lane mask of batch b, batch_idx_o=b.
  - If (b+1)*NUM_LANES < N: increment b and return to FETCH next cycle.
  - Otherwise go to IDLE: done_o pulses and busy_o drops in the same following cycle.
- Timing: start accepted in cycle 0 → reads in cycles 1..T → y_valid_o at cycle T+RD_LATENCY+MAC_LATENCY+1. Each further batch adds T+RD_LATENCY+MAC_LATENCY+1 cycles.
- Width rules: address arithmetic is computed at X_ADDR_WIDTH+1 bits. The config check guarantees no wrap for active lanes. Batch count = ceil(N/NUM_LANES).
- start_i in the same cycle as a done_o pulse: the sequencer is already in IDLE, so the start is accepted (back-to-back jobs).

Decomposition:
- Package fir_seq_pkg holds:
  - the state enum (IDLE/FETCH/DRAIN/CAPTURE);
  - the localparams X_DEPTH, H_DEPTH and DRAIN_CYCLES = RD_LATENCY+MAC_LATENCY;
  - a function computing lane_mask from b, N and NUM_LANES.
- One sub-module, fir_seq_align_dly: a parametrised width/depth shift register used for mac_en_o/mac_first_o alignment. It resets to 0 under the synchronous active-high reset.

Test Plan:
- Defaults, T=16, N=4, start at cycle 0:
  - rd_en_o in cycles 1..16 with h_addr_o 0..15;
  - lane 0 address 15→0 and lane 3 address 18→3;
  - mac_first_o at cycle 2, y_valid_o at cycle 22 with mask 4'b1111;
  - done_o at cycle 23.
- T=5, N=10: three batches with masks 1111, 1111, 0011 and batch_idx_o 0, 1, 2.
  - In the last batch at k=0, lane 1 address = 8+1+4 = 13; lanes 2 and 3 drive address 0.
  - Total 3×(5+5+1) cycles, then done_o.
- Config errors → cfg_err_o pulse, busy_o stays 0, rd_en_o stays 0:
  - T=0;
  - T=17;
  - N=0;
  - N=60 with T=16 (75 > 64).
- rst_n=1 asserted in cycle 8 of FETCH: next cycle all outputs are 0 and state is IDLE; no y_valid_o or done_o follows.
- start_i held high during a job → ignored (no restart). start_i asserted in the done_o cycle → new job; its rd_en_o starts the following cycle.
- RD_LATENCY=3, MAC_LATENCY=6, T=8, N=4: mac_en_o in cycles 4..11, y_valid_o at cycle 18.
